// File: rtl/memctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : memctrl_arb
// Brief    : Multi-channel memory controller; arbitrates requesters onto a
//            shared bus, one transaction at a time, with ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module memctrl_arb #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NUM_CH  = 2,
    parameter int RR_MODE = 0,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_read,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_sel,
    output logic [NUM_CH-1:0]          grant,
    output logic [NUM_CH-1:0]          resp_valid,
    output logic                       resp_err,
    output logic [DATA_W-1:0]          resp_rdata,
    output logic                       bus_read,
    output logic                       bus_write,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [DATA_W-1:0]          bus_wdata,
    output logic [DATA_W/8-1:0]        bus_sel,
    input  logic                       bus_busy,
    input  logic                       bus_ack,
    input  logic [DATA_W-1:0]          bus_rdata,
    output logic [1:0]                 state
);
    localparam int c_sel_w = DATA_W / 8;
    localparam int c_idx_w = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_cnt_w:0] c_timeout = (c_cnt_w + 1)'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_ptr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_is_read;
    logic [NUM_CH-1:0]    r_grant;
    logic [NUM_CH-1:0]    r_resp_valid;
    logic                 r_resp_err;
    logic [DATA_W-1:0]    r_resp_rdata;
    logic                 r_bus_read;
    logic                 r_bus_write;
    logic [ADDR_W-1:0]    r_bus_addr;
    logic [DATA_W-1:0]    r_bus_wdata;
    logic [c_sel_w-1:0]   r_bus_sel;

    logic [ADDR_W-1:0]    w_addr_ch  [NUM_CH];
    logic [DATA_W-1:0]    w_wdata_ch [NUM_CH];
    logic [c_sel_w-1:0]   w_sel_ch   [NUM_CH];
    logic [NUM_CH-1:0]    w_active;
    logic                 w_any;
    logic [c_idx_w-1:0]   w_win;
    logic [c_cnt_w:0]     w_cnt_nxt;
    logic                 w_timeout;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_addr_ch[g]  = req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_ch[g] = req_wdata[g*DATA_W +: DATA_W];
        assign w_sel_ch[g]   = req_sel[g*c_sel_w +: c_sel_w];
    end

    assign w_active = req_read | req_write;

    // Round-robin starts one past the last winner; fixed priority starts at ch0.
    always_comb begin
        int                 start;
        int                 idx;
        logic [c_idx_w-1:0] cand;
        w_any = 1'b0;
        w_win = '0;
        idx   = 0;
        cand  = '0;
        start = (RR_MODE != 0) ? (int'(r_ptr) + 1) % NUM_CH : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx  = (start + k) % NUM_CH;
            cand = c_idx_w'(idx);
            if (!w_any && w_active[cand]) begin
                w_any = 1'b1;
                w_win = cand;
            end
        end
    end

    assign w_cnt_nxt = {1'b0, r_cnt} + (c_cnt_w + 1)'(1);
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_nxt == c_timeout);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= c_idx_w'(NUM_CH - 1);
            r_cnt        <= '0;
            r_is_read    <= 1'b0;
            r_grant      <= '0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_bus_read   <= 1'b0;
            r_bus_write  <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_sel    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_any) begin
                        r_state     <= S_REQUEST;
                        r_ptr       <= w_win;
                        r_grant     <= NUM_CH'(1) << w_win;
                        r_is_read   <= req_read[w_win];
                        r_bus_read  <= req_read[w_win];
                        r_bus_write <= ~req_read[w_win];
                        r_bus_addr  <= w_addr_ch[w_win];
                        r_bus_wdata <= w_wdata_ch[w_win];
                        r_bus_sel   <= w_sel_ch[w_win];
                    end
                end
                S_REQUEST: begin
                    r_cnt <= w_cnt_nxt[c_cnt_w-1:0];
                    if (w_timeout) begin
                        r_state      <= S_RESPOND;
                        r_bus_read   <= 1'b0;
                        r_bus_write  <= 1'b0;
                        r_resp_valid <= r_grant;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end else if (!bus_busy) begin
                        r_state     <= S_WAIT;
                        r_bus_read  <= 1'b0;
                        r_bus_write <= 1'b0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= w_cnt_nxt[c_cnt_w-1:0];
                    // A late ack still completes cleanly even on the expiry cycle.
                    if (bus_ack) begin
                        r_state      <= S_RESPOND;
                        r_resp_valid <= r_grant;
                        r_resp_err   <= 1'b0;
                        r_resp_rdata <= r_is_read ? bus_rdata : '0;
                    end else if (w_timeout) begin
                        r_state      <= S_RESPOND;
                        r_resp_valid <= r_grant;
                        r_resp_err   <= 1'b1;
                        r_resp_rdata <= '0;
                    end
                end
                S_RESPOND: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_is_read    <= 1'b0;
                    r_grant      <= '0;
                    r_resp_valid <= '0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_bus_addr   <= '0;
                    r_bus_wdata  <= '0;
                    r_bus_sel    <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant      = r_grant;
    assign resp_valid = r_resp_valid;
    assign resp_err   = r_resp_err;
    assign resp_rdata = r_resp_rdata;
    assign bus_read   = r_bus_read;
    assign bus_write  = r_bus_write;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_sel    = r_bus_sel;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_memctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_memctrl_arb
// Brief    : Directed self-checking bench; instance 0 fixed priority,
//            1 round-robin, 2 fixed priority with a short timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memctrl_arb;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NC = 2;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     req_read;
    logic [NC-1:0]     req_write;
    logic [NC*AW-1:0]  req_addr;
    logic [NC*DW-1:0]  req_wdata;
    logic [NC*SW-1:0]  req_sel;
    logic              bus_busy;
    logic              bus_ack;
    logic [DW-1:0]     bus_rdata;

    logic [NC-1:0]     grant      [3];
    logic [NC-1:0]     resp_valid [3];
    logic              resp_err   [3];
    logic [DW-1:0]     resp_rdata [3];
    logic              bus_read   [3];
    logic              bus_write  [3];
    logic [AW-1:0]     bus_addr   [3];
    logic [DW-1:0]     bus_wdata  [3];
    logic [SW-1:0]     bus_sel    [3];
    logic [1:0]        state      [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    memctrl_arb #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC), .RR_MODE(0), .TIMEOUT(255)) u_fix (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .grant(grant[0]), .resp_valid(resp_valid[0]), .resp_err(resp_err[0]),
        .resp_rdata(resp_rdata[0]), .bus_read(bus_read[0]), .bus_write(bus_write[0]),
        .bus_addr(bus_addr[0]), .bus_wdata(bus_wdata[0]), .bus_sel(bus_sel[0]),
        .bus_busy(bus_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .state(state[0])
    );

    memctrl_arb #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC), .RR_MODE(1), .TIMEOUT(255)) u_rr (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .grant(grant[1]), .resp_valid(resp_valid[1]), .resp_err(resp_err[1]),
        .resp_rdata(resp_rdata[1]), .bus_read(bus_read[1]), .bus_write(bus_write[1]),
        .bus_addr(bus_addr[1]), .bus_wdata(bus_wdata[1]), .bus_sel(bus_sel[1]),
        .bus_busy(bus_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .state(state[1])
    );

    memctrl_arb #(.ADDR_W(AW), .DATA_W(DW), .NUM_CH(NC), .RR_MODE(0), .TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
        .grant(grant[2]), .resp_valid(resp_valid[2]), .resp_err(resp_err[2]),
        .resp_rdata(resp_rdata[2]), .bus_read(bus_read[2]), .bus_write(bus_write[2]),
        .bus_addr(bus_addr[2]), .bus_wdata(bus_wdata[2]), .bus_sel(bus_sel[2]),
        .bus_busy(bus_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .state(state[2])
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        req_read  = '0;
        req_write = '0;
        bus_busy  = 1'b0;
        bus_ack   = 1'b0;
        bus_rdata = '0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    function automatic logic any_out(input int d);
        return |{grant[d], resp_valid[d], resp_err[d], resp_rdata[d], bus_read[d],
                 bus_write[d], bus_addr[d], bus_wdata[d], bus_sel[d], state[d]};
    endfunction

    logic [1:0] rr_exp [3] = '{2'b01, 2'b10, 2'b01};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset held with live request and bus activity: everything stays zero.
        rst       = 1'b0;
        req_read  = 2'b01;
        req_write = 2'b00;
        req_addr  = {32'h0000_0200, 32'h0000_0100};
        req_wdata = {32'h0000_55AA, 32'h1111_2222};
        req_sel   = 8'h3F;
        bus_busy  = 1'b1;
        bus_ack   = 1'b1;
        bus_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                check("rst_state", 64'(state[d]), 64'd0);
                check("rst_outs", 64'(any_out(d)), 64'd0);
            end
        end
        quiet();
        rst = 1'b1;
        tick();
        check("idle_after_rst", 64'(state[0]), 64'd0);

        // ch0 read, no back-pressure, ack in first WAIT cycle.
        req_read = 2'b01;
        tick();
        check("rd_state_req", 64'(state[0]), 64'd1);
        check("rd_bus_read", 64'(bus_read[0]), 64'd1);
        check("rd_bus_addr", 64'(bus_addr[0]), 64'h100);
        check("rd_grant", 64'(grant[0]), 64'b01);
        tick();
        check("rd_state_wait", 64'(state[0]), 64'd2);
        check("rd_strobe_low", 64'(bus_read[0]), 64'd0);
        bus_ack   = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        tick();
        check("rd_resp_valid", 64'(resp_valid[0]), 64'b01);
        check("rd_resp_rdata", 64'(resp_rdata[0]), 64'hDEAD_BEEF);
        check("rd_resp_err", 64'(resp_err[0]), 64'd0);
        quiet();
        tick();
        check("rd_back_idle", 64'(any_out(0)), 64'd0);
        do_reset();

        // ch1 write with three busy cycles.
        req_write = 2'b10;
        bus_busy  = 1'b1;
        tick();
        check("wr_grant", 64'(grant[0]), 64'b10);
        for (int c = 0; c < 3; c++) begin
            check("wr_hold_state", 64'(state[0]), 64'd1);
            check("wr_hold_strobe", 64'({bus_write[0], bus_read[0]}), 64'b10);
            check("wr_hold_addr", 64'(bus_addr[0]), 64'h200);
            check("wr_hold_wdata", 64'(bus_wdata[0]), 64'h55AA);
            check("wr_hold_sel", 64'(bus_sel[0]), 64'h3);
            tick();
        end
        check("wr_last_req", 64'({state[0], bus_write[0]}), 64'b011);
        bus_busy = 1'b0;
        tick();
        check("wr_state_wait", 64'({state[0], bus_write[0]}), 64'b100);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1234_5678;
        tick();
        check("wr_resp_valid", 64'(resp_valid[0]), 64'b10);
        check("wr_resp_rdata", 64'(resp_rdata[0]), 64'd0);
        quiet();
        do_reset();

        // Both channels read+write held: fixed always ch0 read, RR alternates.
        req_read  = 2'b11;
        req_write = 2'b11;
        req_addr  = {32'h0000_0400, 32'h0000_0300};
        bus_ack   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fix_grant", 64'(grant[0]), 64'b01);
            check("fix_op_read", 64'({bus_read[0], bus_write[0]}), 64'b10);
            check("fix_addr", 64'(bus_addr[0]), 64'h300);
            check("rr_grant", 64'(grant[1]), 64'(rr_exp[i]));
            check("rr_addr", 64'(bus_addr[1]), (rr_exp[i] == 2'b01) ? 64'h300 : 64'h400);
            tick();
            tick();
            check("fix_resp", 64'(resp_valid[0]), 64'b01);
            check("rr_resp", 64'(resp_valid[1]), 64'(rr_exp[i]));
            tick();
            check("dead_idle", 64'(state[0]), 64'd0);
        end
        do_reset();

        // Timeout in WAIT (instance 2, TIMEOUT=4).
        req_read  = 2'b01;
        bus_rdata = 32'h0000_AAAA;
        tick();
        check("to_enter_req", 64'(state[2]), 64'd1);
        tick();
        tick();
        tick();
        check("to_still_wait", 64'({state[2], resp_valid[2]}), {60'd0, 2'd2, 2'b00});
        tick();
        check("to_state", 64'(state[2]), 64'd3);
        check("to_valid", 64'(resp_valid[2]), 64'b01);
        check("to_err", 64'(resp_err[2]), 64'd1);
        check("to_rdata", 64'(resp_rdata[2]), 64'd0);
        check("to_strobes", 64'({bus_read[2], bus_write[2]}), 64'd0);
        do_reset();

        // Timeout while the bus stays busy: expiry beats back-pressure.
        req_read = 2'b01;
        bus_busy = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("tob_hold", 64'({state[2], bus_read[2]}), 64'b011);
        tick();
        check("tob_respond", 64'({state[2], bus_read[2], resp_err[2]}), 64'b1101);
        do_reset();

        // Reset in WAIT abandons the request with no response.
        req_read = 2'b01;
        tick();
        tick();
        check("abn_in_wait", 64'(state[0]), 64'd2);
        rst = 1'b0;
        tick();
        check("abn_idle", 64'(any_out(0)), 64'd0);
        rst       = 1'b1;
        req_read  = 2'b00;
        bus_ack   = 1'b1;
        bus_rdata = 32'hCAFE_F00D;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("abn_no_resp", 64'({state[0], resp_valid[0]}), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
